// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, oversample tick and received-word bundle for uart_rx
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 rx_in;
    logic                 os_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 r_valid;
    logic                 r_busy;
    logic                 frame_err;

    // Host / line side: drives the wire and tick, consumes received words
    modport master (
        output rx_in,
        output os_tick,
        input  data_out,
        input  r_valid,
        input  r_busy,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  rx_in,
        input  os_tick,
        output data_out,
        output r_valid,
        output r_busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with stop-bit framing check
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  u
);
    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] HALF_M1  = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 tick_d_q, tick_d_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 r_valid_q, r_valid_d;
    logic                 r_busy_q, r_busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tick;

    assign tick = u.os_tick & ~tick_d_q;

    // Next-state logic: synchronizer, start-edge detection and the frame FSM
    always_comb begin
        rx_meta_d   = u.rx_in;
        rx_s_d      = rx_meta_q;
        rx_prev_d   = rx_s_q;
        tick_d_d    = u.os_tick;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out_q;
        r_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Needs a real 1->0 edge so a held-low line never retriggers
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_M1) begin
                        state_d    = rx_s_q ? IDLE : DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        // Shift right so the first bit received ends up in the LSB
                        shreg_d    = DATA_BITS'({rx_s_q, shreg_q} >> 1);
                        tick_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_M1) begin
                        // Leave at stop-bit centre so a back-to-back start edge is caught
                        if (rx_s_q) begin
                            data_out_d = shreg_q;
                            r_valid_d  = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
        r_busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            tick_d_q    <= 1'b0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_out_q  <= '0;
            r_valid_q   <= 1'b0;
            r_busy_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            tick_d_q    <= tick_d_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            r_valid_q   <= r_valid_d;
            r_busy_q    <= r_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign u.data_out  = data_out_q;
    assign u.r_valid   = r_valid_q;
    assign u.r_busy    = r_busy_q;
    assign u.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_en = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   n_busy_rise = 0;
    logic [7:0] exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) u ();

    uart_rx #(.DATA_BITS(8), .OS_RATE(16)) dut (
        .clk (clk),
        .rst (rst),
        .u   (u)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-clk os_tick pulse every 4 clk, gated by tick_en
    initial begin
        int tcnt = 0;
        u.os_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            u.os_tick = tick_en && (tcnt == 0);
        end
    end

    // Output monitor: pops the scoreboard on every r_valid
    initial begin
        logic pv = 1'b0, pf = 1'b0, pb = 1'b0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (u.r_valid) begin
                    n_valid++;
                    check("valid_1clk", {31'd0, pv}, 32'd0);
                    check("valid_vs_ferr", {31'd0, u.frame_err}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", {24'd0, u.data_out}, {24'd0, e});
                    end
                end
                if (u.frame_err) begin
                    n_ferr++;
                    check("ferr_1clk", {31'd0, pf}, 32'd0);
                end
                if (u.r_busy && !pb) n_busy_rise++;
            end
            pv = u.r_valid;
            pf = u.frame_err;
            pb = u.r_busy;
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        int g = 0;
        while (k < n) begin
            @(posedge clk);
            if (u.os_tick) begin
                k++;
                g = 0;
            end else begin
                g++;
                if (g > 100) begin
                    check("tick_timeout", 32'd1, 32'd0);
                    k = n;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        u.rx_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            u.rx_in = d[i];
            wait_ticks(16);
        end
        u.rx_in = stop;
        wait_ticks(16);
    endtask

    initial begin
        int busy0;
        logic changed;
        logic [7:0] snap;
        logic [7:0] d5a;
        u.rx_in = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data_out", {24'd0, u.data_out}, 32'd0);
        check("rst_r_valid", {31'd0, u.r_valid}, 32'd0);
        check("rst_r_busy", {31'd0, u.r_busy}, 32'd0);
        check("rst_frame_err", {31'd0, u.frame_err}, 32'd0);
        rst = 1'b0;
        wait_ticks(20);

        // Loopback 0xA5
        send_frame(8'hA5, 1'b1);
        wait_ticks(4);
        check("t1_valid_cnt", n_valid, 1);
        check("t1_ferr_cnt", n_ferr, 0);
        check("t1_busy_low", {31'd0, u.r_busy}, 32'd0);
        check("t1_data", {24'd0, u.data_out}, 32'hA5);

        // Back-to-back with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        check("t2_valid_cnt", n_valid, 3);
        check("t2_ferr_cnt", n_ferr, 0);

        // Glitch shorter than half a bit
        busy0 = n_busy_rise;
        u.rx_in = 1'b0;
        wait_ticks(3);
        u.rx_in = 1'b1;
        wait_ticks(20);
        check("t3_busy_pulse", n_busy_rise, busy0 + 1);
        check("t3_busy_low", {31'd0, u.r_busy}, 32'd0);
        check("t3_no_valid", n_valid, 3);
        check("t3_data_kept", {24'd0, u.data_out}, 32'hFF);

        // Framing error, then line held low (break)
        send_frame(8'h3C, 1'b0);
        busy0 = n_busy_rise;
        wait_ticks(48);
        check("t4_ferr_cnt", n_ferr, 1);
        check("t4_no_valid", n_valid, 3);
        check("t4_data_kept", {24'd0, u.data_out}, 32'hFF);
        check("t4_no_retrigger", n_busy_rise, busy0);
        check("t4_busy_low", {31'd0, u.r_busy}, 32'd0);
        u.rx_in = 1'b1;
        wait_ticks(16);

        // Reset in the middle of data bit 4 of 0x5A
        d5a = 8'h5A;
        u.rx_in = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            u.rx_in = d5a[i];
            wait_ticks(16);
        end
        u.rx_in = d5a[4];
        wait_ticks(8);
        check("t5_busy_before", {31'd0, u.r_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_data_out", {24'd0, u.data_out}, 32'd0);
        check("t5_r_valid", {31'd0, u.r_valid}, 32'd0);
        check("t5_r_busy", {31'd0, u.r_busy}, 32'd0);
        check("t5_frame_err", {31'd0, u.frame_err}, 32'd0);
        u.rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        wait_ticks(8);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        check("t5_valid_cnt", n_valid, 4);
        check("t5_ferr_cnt", n_ferr, 1);

        // Tick stall mid-frame
        changed = 1'b0;
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_ticks(16 * 4 + 5);
                tick_en = 1'b0;
                @(negedge clk);
                snap = u.data_out;
                repeat (50) begin
                    @(negedge clk);
                    if (u.r_busy !== 1'b1 || u.r_valid !== 1'b0 ||
                        u.frame_err !== 1'b0 || u.data_out !== snap)
                        changed = 1'b1;
                end
                check("t6_frozen", {31'd0, changed}, 32'd0);
                check("t6_busy_held", {31'd0, u.r_busy}, 32'd1);
                tick_en = 1'b1;
            end
        join
        wait_ticks(4);
        check("t6_valid_cnt", n_valid, 5);
        check("t6_data", {24'd0, u.data_out}, 32'h96);
        check("t6_busy_low", {31'd0, u.r_busy}, 32'd0);

        check("sb_empty", exp_q.size(), 0);
        check("final_ferr_cnt", n_ferr, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
